// File: rtl/ram_fifo_ctrl.sv
// Pointer/flag controller turning an external dual-port RAM into a first-word-fall-through FIFO.
// Latency: write visible at the head one cycle after the push edge; read data is combinational from the RAM.
// Backpressure: s_ready drops when full or flushing; m_data holds while m_valid && !m_ready.
module ram_fifo_ctrl #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 2,
    parameter int AF_LEVEL = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              almost_full
);

    localparam int            DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              push;
    logic              pop;

    assign empty       = (cnt == '0);
    assign full        = (cnt == DEPTH_C);
    assign almost_full = (cnt >= AF_C);
    assign count       = cnt;

    assign s_ready = !full && !flush;
    assign push    = s_valid && s_ready;
    assign m_valid = !empty && !flush;
    assign pop     = m_valid && m_ready;

    assign ram_we    = push;
    assign ram_waddr = wr_ptr;
    assign ram_wdata = s_data;
    assign ram_raddr = rd_ptr;
    assign m_data    = ram_rdata;

    // Full vs. empty is told apart by cnt alone; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_data;
    logic       ram_we;
    logic [1:0] ram_waddr;
    logic [3:0] ram_wdata;
    logic [1:0] ram_raddr;
    logic [3:0] ram_rdata;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;

    int tests = 0;
    int fails = 0;

    ram_fifo_ctrl #(.DATA_W(4), .ADDR_W(2), .AF_LEVEL(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4x4 dual-port RAM: synchronous write on port A, combinational read on port B.
    logic [3:0] ram [4];
    always @(posedge clk) if (ram_we) ram[ram_waddr] <= ram_wdata;
    assign ram_rdata = ram[ram_raddr];

    // Reference model: contents as a queue, addresses as running push/pop totals mod 4.
    logic [3:0] q[$];
    int n_push = 0;
    int n_pop  = 0;

    always @(negedge rst_n) begin
        q.delete();
        n_push = 0;
        n_pop  = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q.delete();
                n_push = 0;
                n_pop  = 0;
            end else begin
                bit do_push;
                bit do_pop;
                do_push = s_valid && (q.size() < 4);
                do_pop  = m_ready && (q.size() > 0);
                if (do_pop) begin
                    void'(q.pop_front());
                    n_pop++;
                end
                if (do_push) begin
                    q.push_back(s_data);
                    n_push++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, mid-way through the low clock phase.
    always @(negedge clk) begin
        #3;
        begin
            int  sz;
            bit  exp_rdy;
            bit  exp_vld;
            sz      = q.size();
            exp_rdy = (sz < 4) && !flush;
            exp_vld = (sz > 0) && !flush;
            chk("count", 32'(count), 32'(sz));
            chk("empty", 32'(empty), 32'(sz == 0));
            chk("full", 32'(full), 32'(sz == 4));
            chk("almost_full", 32'(almost_full), 32'(sz >= 3));
            chk("s_ready", 32'(s_ready), 32'(exp_rdy));
            chk("m_valid", 32'(m_valid), 32'(exp_vld));
            chk("ram_we", 32'(ram_we), 32'(s_valid && exp_rdy));
            chk("ram_wdata", 32'(ram_wdata), 32'(s_data));
            chk("ram_waddr", 32'(ram_waddr), 32'(n_push % 4));
            chk("ram_raddr", 32'(ram_raddr), 32'(n_pop % 4));
            if (exp_vld) chk("m_data", 32'(m_data), 32'(q[0]));
            if (count > 3'd4) chk("count_range", 32'(count), 32'd4);
        end
    end

    // Drive one cycle's inputs after the falling edge, then settle for literal checks.
    task automatic cyc(input bit v, input logic [3:0] d, input bit r, input bit f);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        flush   = f;
        #2;
    endtask

    initial begin
        logic [3:0] held;
        logic [1:0] held_ra;
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 1..4 with no reads.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'(i + 1), 1'b0, 1'b0);
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_waddr", 32'(ram_waddr), 32'(i));
            chk("fill_af", 32'(almost_full), 32'(i >= 3));
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 4; i++) chk("ram_content", 32'(ram[i]), 32'(i + 1));

        // Drain from full.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'h0, 1'b1, 1'b0);
            chk("drain_data", 32'(m_data), 32'(i + 1));
            chk("drain_valid", 32'(m_valid), 32'd1);
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_m_valid", 32'(m_valid), 32'd0);

        // Wrap-around with occupancy held at 2.
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        cyc(1'b1, 4'hB, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 4'(i + 3), 1'b1, 1'b0);
            chk("wrap_count", 32'(count), 32'd2);
            chk("wrap_waddr", 32'(ram_waddr), 32'((i + 2) % 4));
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("pushpop_count", 32'(count), 32'd2);

        // Push+pop requested at full: only the pop happens.
        cyc(1'b1, 4'h7, 1'b0, 1'b0);
        cyc(1'b1, 4'h8, 1'b0, 1'b0);
        cyc(1'b1, 4'h5, 1'b1, 1'b0);
        chk("full_pp_s_ready", 32'(s_ready), 32'd0);
        chk("full_pp_we", 32'(ram_we), 32'd0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("full_pp_count", 32'(count), 32'd3);

        // Backpressure at count 1.
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("bp_count", 32'(count), 32'd1);
        held    = m_data;
        held_ra = ram_raddr;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'h0, 1'b0, 1'b0);
            chk("bp_data", 32'(m_data), 32'(held));
            chk("bp_raddr", 32'(ram_raddr), 32'(held_ra));
        end

        // Flush at count 3 with a push attempt.
        cyc(1'b1, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b1, 1'b1);
        chk("flush_count_pre", 32'(count), 32'd3);
        chk("flush_we", 32'(ram_we), 32'd0);
        chk("flush_s_ready", 32'(s_ready), 32'd0);
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);

        // Asynchronous reset between edges at count 2.
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("pre_arst_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 24) == 0));
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        #4;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Pointer and flag controller that turns the team's 4-entry × 4-bit dual-port RAM into a first-word-fall-through FIFO. It sits directly upstream of the RAM. It drives RAM port A as the write port and RAM port B as the read port, with port B's write enable tied low at the top level. The RAM's read data returns combinationally, so the block presents a valid/ready stream on both sides and adds no read latency.

## Interface

Parameters:
- `DATA_W`, default 4: data width; must match the RAM word width.
- `ADDR_W`, default 2: RAM address width. Depth is DEPTH = 2**ADDR_W.
- `AF_LEVEL`, default 3: `almost_full` asserts when `count` >= AF_LEVEL. Legal range 1..DEPTH.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous clear of FIFO contents.
- `s_valid`, in, 1: write-side data valid.
- `s_ready`, out, 1: write-side ready.
- `s_data`, in, DATA_W: write-side data.
- `m_valid`, out, 1: read-side data valid.
- `m_ready`, in, 1: read-side ready.
- `m_data`, out, DATA_W: read-side data.
- `ram_we`, out, 1: drives RAM `wea`.
- `ram_waddr`, out, ADDR_W: drives RAM `addra`.
- `ram_wdata`, out, DATA_W: drives RAM `dina`.
- `ram_raddr`, out, ADDR_W: drives RAM `addrb`.
- `ram_rdata`, in, DATA_W: from RAM `doutb`.
- `count`, out, ADDR_W+1: current occupancy, 0..DEPTH.
- `empty`, out, 1: `count` == 0.
- `full`, out, 1: `count` == DEPTH.
- `almost_full`, out, 1: `count` >= AF_LEVEL.

## Operation

State is held in three registers:
- `wr_ptr`, ADDR_W bits.
- `rd_ptr`, ADDR_W bits.
- `cnt`, ADDR_W+1 bits.

All flags are decoded combinationally from `cnt`.

Handshake and RAM drive:
- `s_ready` = !full && !flush.
- push = s_valid && s_ready.
- `ram_we` = push. `ram_waddr` = `wr_ptr`. `ram_wdata` = `s_data`. All three are combinational.
- `m_valid` = !empty && !flush.
- pop = m_valid && m_ready.
- `ram_raddr` = `rd_ptr`. `m_data` = `ram_rdata`. Both are combinational pass-through.
- `m_data` is held stable while `m_valid` && !m_ready, because `rd_ptr` does not move.

Register update on each clock edge, in priority order:
- flush: `wr_ptr`, `rd_ptr` and `cnt` go to 0. Any push or pop in that cycle is suppressed.
- push only: `wr_ptr` += 1, `cnt` += 1.
- pop only: `rd_ptr` += 1, `cnt` -= 1.
- push and pop together: both pointers advance; `cnt` is unchanged.
- neither: hold.

Pointer arithmetic:
- Both pointers wrap modulo DEPTH (3 → 0), with no extra wrap bit.
- Full and empty are distinguished only by `cnt`.

Boundary conditions:
- Full: `s_ready` = 0, and a push cannot occur. There is no full-bypass, so a pop while full frees a slot only for the following cycle.
- Empty: `m_valid` = 0, and a pop cannot occur. There is no write-to-read bypass; data written at edge N is visible on `m_data` after edge N.
- `cnt` never exceeds DEPTH and never underflows. The bench treats either as an assertion failure.

## Timing

- Reset (`rst_n` = 0, asynchronous) sets `wr_ptr` = 0, `rd_ptr` = 0, `cnt` = 0. Resulting outputs:
  - `empty` = 1, `full` = 0, `almost_full` = 0, `count` = 0.
  - `m_valid` = 0, `s_ready` = 1 (when `flush` = 0).
  - `ram_we` follows `s_valid`. Upstream must hold `s_valid` low during reset.
- Reset mid-operation discards all contents immediately. RAM contents are not cleared and are never read until rewritten.
- Write latency: 1 cycle. A push accepted at edge N appears at the FIFO head on `m_data` in cycle N+1 if the FIFO was empty.
- Read latency: 0 cycles. The pop handshake completes in the same cycle `m_valid` and `m_ready` are high.
- Throughput: 1 push and 1 pop per cycle, sustained, whenever 0 < `cnt` < DEPTH.
- `flush` takes effect at the next edge. During the flush cycle, `s_ready`, `m_valid` and `ram_we` are forced to 0.

## Test plan

1. **Reset then fill:** push 0x1, 0x2, 0x3, 0x4 on consecutive cycles with `m_ready` = 0.
   - `count` steps 1→4.
   - `almost_full` rises after the third push.
   - `full` = 1 and `s_ready` = 0 after the fourth push.
   - RAM addresses 0..3 hold 1..4.
2. **Drain:** with `m_ready` = 1 from full, `m_data` reads 0x1, 0x2, 0x3, 0x4 on consecutive cycles. `empty` = 1 and `m_valid` = 0 afterwards.
3. **Wrap-around:** run 10 pushes interleaved with pops holding `count` at 2. Data order is preserved, and `ram_waddr` sequences 0,1,2,3,0,1,….
4. **Simultaneous push and pop at `count` = 2:**
   - `count` stays 2 and both pointers advance.
   - At full with push+pop requested, only the pop occurs and `count` = 3.
5. **Backpressure:** at `count` = 1 with `m_ready` = 0 for 5 cycles, `m_data` holds a stable value and `rd_ptr` stays unchanged.
6. **Flush and async reset mid-stream:**
   - `flush` at `count` = 3: the next cycle shows `count` = 0, `empty` = 1, and the push in the flush cycle is not written.
   - `rst_n` low at `count` = 2, asserted between clock edges: `count` = 0 immediately.
